// File: rtl/mul_pkg.sv
// Shared constants for the parametrised sequential multiplier: iteration count,
// FSM state encoding and the legal-radix check.
`ifndef MUL_PKG_SV
`define MUL_PKG_SV

`define MUL_RADIX_LEGAL(r) (((r) == 1) || ((r) == 2) || ((r) == 4) || ((r) == 8))

package mul_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Digits needed to cover the WIDTH+1-bit extended multiplier: ceil((w+1)/r).
  function automatic int ITER_OF(input int width, input int radix_bits);
    return (width + radix_bits) / radix_bits;
  endfunction

endpackage

`endif

// File: rtl/mul_digit_step.sv
// One radix-2^RADIX_BITS step: acc + a_ext*digit, then an arithmetic shift right.
// The retired low bits of the sum leave on lo_o.
module mul_digit_step #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 4
) (
  input  logic [WIDTH+RADIX_BITS+1:0] acc_i,
  input  logic [WIDTH:0]              a_ext_i,
  input  logic [RADIX_BITS-1:0]       digit_i,
  input  logic                        top_i,
  output logic [WIDTH+RADIX_BITS+1:0] acc_o,
  output logic [RADIX_BITS-1:0]       lo_o
);

  localparam int AW = WIDTH + RADIX_BITS + 2;

  logic [AW-1:0] a_x;
  logic [AW-1:0] d_x;
  logic [AW-1:0] sum;
  logic          d_sign;

  // Only the top digit is signed; the others are plain unsigned digits.
  always_comb begin
    d_sign = top_i & digit_i[RADIX_BITS-1];
    a_x    = {{(AW-WIDTH-1){a_ext_i[WIDTH]}}, a_ext_i};
    d_x    = {{(AW-RADIX_BITS){d_sign}}, digit_i};
    sum    = acc_i + (a_x * d_x);
    acc_o  = {{RADIX_BITS{sum[AW-1]}}, sum[AW-1:RADIX_BITS]};
    lo_o   = sum[RADIX_BITS-1:0];
  end

endmodule

// File: rtl/mul_seq_param.sv
// Iterative RV32M-style multiplier retiring RADIX_BITS multiplier bits per cycle,
// with a cached full product so a repeated operand pair completes without iterating.
module mul_seq_param
  import mul_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 4,
  parameter int REUSE_EN   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ua,
  input  logic             ub,
  input  logic             hm,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  localparam int ITER = ITER_OF(WIDTH, RADIX_BITS);
  localparam int MQW  = ITER * RADIX_BITS;
  localparam int AW   = WIDTH + RADIX_BITS + 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam int PW   = 2 * WIDTH;
  localparam int TW   = 2 * WIDTH + 2;
  localparam bit RADIX_OK = `MUL_RADIX_LEGAL(RADIX_BITS);

  if (!RADIX_OK) begin : g_bad_radix
    $error("mul_seq_param: RADIX_BITS must be 1, 2, 4 or 8");
  end

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   a_ext_q, a_ext_d;
  logic [MQW-1:0]   mq_q, mq_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [MQW-1:0]   lo_q, lo_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [TW-1:0]    tag_q, tag_d;
  logic             hm_q, hm_d;
  logic             cache_valid_q, cache_valid_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic [TW-1:0]         tag_in;
  logic                  hit;
  logic [WIDTH:0]        b_ext_in;
  logic [MQW-1:0]        b_pad;
  logic [AW-1:0]         step_acc;
  logic [RADIX_BITS-1:0] step_lo;
  logic [MQW-1:0]        lo_next;
  logic [PW-1:0]         prod_new;

  mul_digit_step #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_step (
    .acc_i   (acc_q),
    .a_ext_i (a_ext_q),
    .digit_i (mq_q[RADIX_BITS-1:0]),
    .top_i   (cnt_q == CW'(1)),
    .acc_o   (step_acc),
    .lo_o    (step_lo)
  );

  // The multiplier is sign-padded up to a whole number of digits so the top
  // digit, read as signed, carries the extension bit's negative weight.
  always_comb begin
    tag_in   = {a, b, ua, ub};
    hit      = (REUSE_EN != 0) && cache_valid_q && (tag_in == tag_q);
    b_ext_in = {~ub & b[WIDTH-1], b};
    b_pad    = MQW'($signed(b_ext_in));
    lo_next  = MQW'({step_lo, lo_q} >> RADIX_BITS);
    prod_new = PW'({step_acc, lo_next});
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_ext_d       = a_ext_q;
    mq_d          = mq_q;
    acc_d         = acc_q;
    lo_d          = lo_q;
    prod_d        = prod_q;
    tag_d         = tag_q;
    hm_d          = hm_q;
    cache_valid_d = cache_valid_q;
    done_d        = 1'b0;
    out_d         = out_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          hm_d = hm;
          if (hit) begin
            done_d = 1'b1;
            out_d  = hm ? prod_q[PW-1:WIDTH] : prod_q[WIDTH-1:0];
          end else begin
            a_ext_d       = {~ua & a[WIDTH-1], a};
            mq_d          = b_pad;
            acc_d         = '0;
            lo_d          = '0;
            tag_d         = tag_in;
            cache_valid_d = 1'b0;
            cnt_d         = CW'(ITER);
            state_d       = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d = step_acc;
        lo_d  = lo_next;
        mq_d  = mq_q >> RADIX_BITS;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          prod_d        = prod_new;
          cache_valid_d = 1'b1;
          done_d        = 1'b1;
          out_d         = hm_q ? prod_new[PW-1:WIDTH] : prod_new[WIDTH-1:0];
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      a_ext_q       <= '0;
      mq_q          <= '0;
      acc_q         <= '0;
      lo_q          <= '0;
      prod_q        <= '0;
      tag_q         <= '0;
      hm_q          <= 1'b0;
      cache_valid_q <= 1'b0;
      done_q        <= 1'b0;
      out_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      a_ext_q       <= a_ext_d;
      mq_q          <= mq_d;
      acc_q         <= acc_d;
      lo_q          <= lo_d;
      prod_q        <= prod_d;
      tag_q         <= tag_d;
      hm_q          <= hm_d;
      cache_valid_q <= cache_valid_d;
      done_q        <= done_d;
      out_q         <= out_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_mul_seq_param.sv
// Bench for mul_seq_param: five instances (radix 4/1/2/8 with reuse, radix 4 without)
// driven by directed steps and a random sweep, checked by a per-instance scoreboard.
module tb_mul_seq_param;

  localparam int NI = 5;

  function automatic int radix_of(input int k);
    case (k)
      1:       return 1;
      2:       return 2;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic int reuse_of(input int k);
    return (k == 4) ? 0 : 1;
  endfunction

  function automatic int iter_of(input int k);
    return (33 + radix_of(k) - 1) / radix_of(k);
  endfunction

  logic        clk;
  logic        rst;
  logic [31:0] a_s   [NI];
  logic [31:0] b_s   [NI];
  logic        ua_s  [NI];
  logic        ub_s  [NI];
  logic        hm_s  [NI];
  logic        load_s[NI];
  logic        busy_s[NI];
  logic        done_s[NI];
  logic [31:0] out_s [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    mul_seq_param #(
      .WIDTH      (32),
      .RADIX_BITS (radix_of(k)),
      .REUSE_EN   (reuse_of(k))
    ) u_dut (
      .clk   (clk),
      .reset (rst),
      .a     (a_s[k]),
      .b     (b_s[k]),
      .ua    (ua_s[k]),
      .ub    (ub_s[k]),
      .hm    (hm_s[k]),
      .load  (load_s[k]),
      .busy  (busy_s[k]),
      .done  (done_s[k]),
      .out   (out_s[k])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [31:0] exp_q  [NI][$];
  int          expb_q [NI][$];
  bit          cv     [NI];
  logic [65:0] ctag   [NI];
  int          bcnt   [NI];
  int          lcnt   [NI];
  int          total;
  int          bad;

  function automatic logic [31:0] ref_out(input logic [31:0] a, input logic [31:0] b,
                                          input logic ua, input logic ub, input logic hm);
    logic signed [63:0] sa, sb, p;
    sa = ua ? $signed({32'd0, a}) : $signed({{32{a[31]}}, a});
    sb = ub ? $signed({32'd0, b}) : $signed({{32{b[31]}}, b});
    p  = sa * sb;
    return hm ? p[63:32] : p[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: one-cycle load pulse on every masked instance; expectations pushed if idle
  task automatic issue(input logic [NI-1:0] mask, input logic [31:0] a, input logic [31:0] b,
                       input logic ua, input logic ub, input logic hm, input bit now);
    logic [65:0] tag;
    bit          hit;
    if (!now) begin
      @(posedge clk);
      #1;
    end
    tag = {a, b, ua, ub};
    for (int k = 0; k < NI; k++) begin
      if (mask[k]) begin
        a_s[k] = a; b_s[k] = b; ua_s[k] = ua; ub_s[k] = ub; hm_s[k] = hm;
        load_s[k] = 1'b1;
        if (!busy_s[k]) begin
          hit = (reuse_of(k) != 0) && cv[k] && (ctag[k] == tag);
          exp_q[k].push_back(ref_out(a, b, ua, ub, hm));
          expb_q[k].push_back(hit ? 0 : iter_of(k));
          if (!hit) begin
            ctag[k] = tag;
            cv[k]   = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) load_s[k] = 1'b0;
  endtask

  function automatic bit pending(input logic [NI-1:0] mask);
    bit p = 1'b0;
    for (int k = 0; k < NI; k++) if (mask[k] && exp_q[k].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_idle(input logic [NI-1:0] mask);
    int n = 0;
    while (n < 200 && pending(mask)) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    assert (!pending(mask)) else begin
      bad++;
      $error("FAIL timeout mask=%b got=pending exp=drained", mask);
    end
  endtask

  task automatic flush_model();
    for (int k = 0; k < NI; k++) begin
      exp_q[k].delete();
      expb_q[k].delete();
      cv[k] = 1'b0;
    end
  endtask

  // monitor: compare on every done pulse, away from the active edge
  always @(negedge clk) begin
    logic [31:0] e;
    int          eb;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        bcnt[k] = 0;
        lcnt[k] = 0;
      end else begin
        lcnt[k]++;
        if (busy_s[k]) bcnt[k]++;
        if (done_s[k]) begin
          total++;
          assert (exp_q[k].size() != 0) else begin
            bad++;
            $error("FAIL spurious_done k=%0d got=1 exp=0", k);
          end
          if (exp_q[k].size() != 0) begin
            e  = exp_q[k].pop_front();
            eb = expb_q[k].pop_front();
            total++;
            assert (out_s[k] === e) else begin
              bad++;
              $error("FAIL out k=%0d got=%h exp=%h", k, out_s[k], e);
            end
            total++;
            assert (bcnt[k] === eb) else begin
              bad++;
              $error("FAIL busy_cycles k=%0d got=%0d exp=%0d", k, bcnt[k], eb);
            end
            total++;
            assert (lcnt[k] === eb + 1) else begin
              bad++;
              $error("FAIL done_latency k=%0d got=%0d exp=%0d", k, lcnt[k], eb + 1);
            end
          end
          bcnt[k] = 0;
        end
        if (load_s[k] && !busy_s[k]) lcnt[k] = 0;
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    int          n;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int k = 0; k < NI; k++) begin
      a_s[k] = '0; b_s[k] = '0; ua_s[k] = 1'b0; ub_s[k] = 1'b0; hm_s[k] = 1'b0;
      load_s[k] = 1'b0; bcnt[k] = 0; lcnt[k] = 0;
    end
    flush_model();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_busy", {31'd0, busy_s[k]}, 32'd0);
      check("rst_done", {31'd0, done_s[k]}, 32'd0);
      check("rst_out", out_s[k], 32'd0);
    end
    rst = 1'b0;

    // basic unsigned, mixed signedness with a reuse hit
    issue(5'b00001, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle(5'b00001);
    issue(5'b00001, 32'd5, 32'hFFFF_FFF9, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_idle(5'b00001);
    issue(5'b00001, 32'd5, 32'hFFFF_FFF9, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle(5'b00001);

    // all-ones: signedness is part of the tag
    issue(5'b00001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_idle(5'b00001);
    issue(5'b00001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle(5'b00001);
    issue(5'b00001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle(5'b00001);

    // signed corners
    issue(5'b00001, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle(5'b00001);
    issue(5'b00001, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle(5'b00001);

    // load while busy is ignored; result then held
    issue(5'b00001, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    issue(5'b00001, 32'd9, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle(5'b00001);
    repeat (3) @(posedge clk);
    #1;
    check("out_hold", out_s[0], 32'h0000_0023);

    // reset in the middle of a run
    issue(5'b00001, 32'd3, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    flush_model();
    @(posedge clk);
    #1;
    check("abort_busy", {31'd0, busy_s[0]}, 32'd0);
    check("abort_done", {31'd0, done_s[0]}, 32'd0);
    check("abort_out", out_s[0], 32'd0);
    rst = 1'b0;
    issue(5'b00001, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle(5'b00001);
    issue(5'b00001, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_idle(5'b00001);

    // back-to-back: new load in the done cycle
    issue(5'b00001, 32'd11, 32'd13, 1'b1, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (n < 40 && !done_s[0]) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_done_seen", {31'd0, done_s[0]}, 32'd1);
    issue(5'b00001, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_idle(5'b00001);

    // reuse disabled: identical repeat still iterates on instance 4
    issue(5'b10001, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle(5'b10001);
    issue(5'b10001, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle(5'b10001);

    // random sweep across radix 4, 1, 2, 8 in parallel
    for (int i = 0; i < 1000; i++) begin
      ra = pick();
      rb = pick();
      issue(5'b01111, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b0);
      wait_idle(5'b01111);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
